snn_neuron_update: RTL and testbench
====================================

// Module: snn_neuron_update
// PURPOSE
//  Per-SPE leaky integrate-and-fire update stage, directly upstream of output memory.
//  - Takes one 13-bit partial sum per output neuron.
//  - In timestep 2 it first fetches the stored residual from output memory over the router.
//  - Applies threshold; emits one STORE packet {residual, spike} to output memory per neuron.
//  - Tracks timestep sync: waits for TIMESTEP_DONE (opcode 15) between timesteps.
// PARAMETERS
//  SPE_ID          0     this SPE's index 0..4; STORE opcode=2*SPE_ID, REQ opcode=2*SPE_ID+1
//  OMEM_ADDR       11    4-bit router address of output memory
//  THRESHOLD       64    firing threshold, unsigned, < 2**SUM_WIDTH
//  NEURONS_PER_TS  89    neurons handled per timestep (89 for SPE0, 88 for SPE1..4)
//  LEAK_SHIFT      1     residual right-shift when SNN_LEAK_EN is defined
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   async active-low reset
//  psum_valid  in   1   partial sum offered
//  psum_ready  out  1   partial sum accepted when valid&ready
//  psum_data   in   13  signed partial sum
//  tx_valid    out  1   router packet offered
//  tx_ready    in   1   router accepts on valid&ready
//  tx_packet   out  33  [32:29] dest, [28:25] opcode, [24:0] data
//  rx_valid    in   1   router packet offered to SPE
//  rx_ready    out  1   packet consumed on valid&ready
//  rx_packet   in   33  same format
//  busy        out  1   high in any state but IDLE/DONE
//  layer_done  out  1   high in DONE
//  err         out  1   sticky protocol error
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; ts=1; nidx=0; state=IDLE; err=0.
//  - Reset mid-operation abandons any in-flight packet; tx_valid drops immediately.
//  FSM: IDLE -> (ts==2 ? REQ -> WAIT_RES : -) -> COMPUTE -> SEND -> IDLE | WAIT_TS | DONE.
//  - IDLE: psum_ready=1; on accept latch psum.
//    - ts==1: residual=0, go to COMPUTE.
//    - ts==2: go to REQ.
//  - REQ: tx_packet={OMEM_ADDR, 2*SPE_ID+1, 25'd0}, tx_valid=1; on tx_ready go to WAIT_RES.
//  - WAIT_RES: rx_ready=1; on a packet with dest==SPE_ID and opcode!=15:
//    residual=data[12:0] (unsigned), go to COMPUTE.
//  - COMPUTE (1 cycle): via snn_lif_core.
//    - pot = clamp(sext(psum)+zext(res), 0, 8191), computed in 15-bit signed.
//    - spike = pot>=THRESHOLD; res_out = spike ? pot-THRESHOLD : pot.
//  - SEND: tx_packet={OMEM_ADDR, 2*SPE_ID, 11'd0, res_out[12:0], spike}, tx_valid=1.
//    - On tx_ready: nidx++.
//    - nidx==NEURONS_PER_TS: go to WAIT_TS (ts==1) or DONE (ts==2); otherwise go to IDLE.
//  - WAIT_TS: rx_ready=1; on opcode 15: ts=2, nidx=0, go to IDLE.
//  - DONE: layer_done=1; held until reset.
//  Handshakes:
//  - tx_packet is stable while tx_valid&!tx_ready.
//  - tx_valid is never withdrawn without a transfer, except on reset.
//  Latency, ts1: psum accept at cycle 0, tx_valid at cycle 2; zero-wait loop is 3 cycles/neuron.
//  rx handling:
//  - rx_ready=1 also in IDLE/REQ/COMPUTE/SEND/DONE, acting as a drain.
//  - Any packet consumed outside its expected state, or with dest!=SPE_ID, is dropped and sets err.
//  - A non-15 reply in WAIT_TS, or opcode 15 in WAIT_RES, is dropped and sets err.
//  - psum is never accepted outside IDLE; rx and tx may complete in the same cycle.
// CONFIGURATION
//  SNN_LEAK_EN defined: in ts2, res = rx_data[12:0] >> LEAK_SHIFT before the add.
//  SNN_LEAK_EN undefined: residual is used unmodified; LEAK_SHIFT is ignored.
// STRUCTURE
//  snn_pkg holds:
//  - packet field localparams and packet_t struct;
//  - opcode constants (STORE base, REQ base, OP_TIMESTEP_DONE=15);
//  - SUM_WIDTH=13 and the state enum.
//  Sub-module snn_lif_core: combinational add/clamp/leak/threshold, registered by the parent.
// TESTING
//  1 SPE_ID=2, ts1, psum=100 -> tx {dest 11, op 4, data 73} (res 36, spike 1).
//  2 ts1, psum=-20 -> pot clamps to 0 -> data 0, spike 0.
//  3 89 psums, then rx opcode 15 -> ts=2; psum=30 -> REQ op 5.
//    Reply data 40 -> pot 70 -> data 13 (res 6, spike 1).
//  4 tx_ready low 5 cycles in SEND -> tx_packet unchanged, psum_ready=0; completes on ready.
//  5 rx dest=3 to SPE_ID=2, or opcode 15 in IDLE -> packet dropped, err=1; FSM unaffected.
//  6 rst_n=0 in WAIT_RES -> tx_valid/psum_ready 0 at once; after release ts=1, nidx=0, IDLE.
//  7 SNN_LEAK_EN, LEAK_SHIFT=1: reply 40, psum 30 -> pot 50, no spike, data 100.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the SNN neuron update slice.
//   - Router packet layout: [32:29] dest, [28:25] opcode, [24:0] data.
//   - Opcode bases: STORE = 2*SPE_ID, REQ = 2*SPE_ID+1, TIMESTEP_DONE = 15.
//   - SUM_WIDTH: width of partial sums, residuals and membrane potential.
//   - state_t: update FSM states (also visible as the top's `state` signal).
// Compile-time option used by the slice: SNN_LEAK_EN (see snn_lif_core).
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int SUM_WIDTH  = 13;

    localparam int DEST_WIDTH = 4;
    localparam int OP_WIDTH   = 4;
    localparam int DATA_WIDTH = 25;
    localparam int PKT_WIDTH  = DEST_WIDTH + OP_WIDTH + DATA_WIDTH;

    localparam int PKT_DEST_LSB = DATA_WIDTH + OP_WIDTH;  // 29
    localparam int PKT_OP_LSB   = DATA_WIDTH;             // 25

    localparam logic [OP_WIDTH-1:0] OP_STORE_BASE    = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_REQ_BASE      = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_TIMESTEP_DONE = 4'd15;

    typedef struct packed {
        logic [DEST_WIDTH-1:0] dest;
        logic [OP_WIDTH-1:0]   opcode;
        logic [DATA_WIDTH-1:0] data;
    } packet_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_TS  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    function automatic packet_t make_packet(input logic [DEST_WIDTH-1:0] dest,
                                            input logic [OP_WIDTH-1:0]   opcode,
                                            input logic [DATA_WIDTH-1:0] data);
        packet_t p;
        p.dest   = dest;
        p.opcode = opcode;
        p.data   = data;
        return p;
    endfunction

endpackage

// File: rtl/snn_lif_core.sv
// -----------------------------------------------------------------------------
// snn_lif_core
// Combinational leaky integrate-and-fire step. The parent registers outputs.
//   psum    in  13  signed partial sum
//   res     in  13  unsigned stored residual (0 in timestep 1)
//   res_out out 13  residual to store (pot - THRESHOLD when spiking, else pot)
//   spike   out 1   pot >= THRESHOLD
// Option SNN_LEAK_EN: when defined, the residual is right-shifted by
// LEAK_SHIFT before the add; otherwise LEAK_SHIFT has no effect.
// -----------------------------------------------------------------------------
module snn_lif_core
    import snn_pkg::*;
#(
    parameter int THRESHOLD  = 64,
    parameter int LEAK_SHIFT = 1
) (
    input  logic signed [SUM_WIDTH-1:0] psum,
    input  logic        [SUM_WIDTH-1:0] res,
    output logic        [SUM_WIDTH-1:0] res_out,
    output logic                        spike
);

    localparam logic [SUM_WIDTH-1:0] THR     = SUM_WIDTH'(THRESHOLD);
    localparam logic [SUM_WIDTH-1:0] POT_MAX = '1;

    logic        [SUM_WIDTH-1:0] res_eff;
    logic signed [SUM_WIDTH+1:0] sum;
    logic        [SUM_WIDTH-1:0] pot;

`ifdef SNN_LEAK_EN
    assign res_eff = res >> LEAK_SHIFT;
`else
    localparam int unused_leak_shift = LEAK_SHIFT;
    assign res_eff = res;
`endif

    // Two guard bits: -4096..+12286 fits in 15-bit signed without wrap.
    assign sum = $signed({{2{psum[SUM_WIDTH-1]}}, psum}) + $signed({2'b00, res_eff});

    // Clamp to 0..8191: sign bit -> 0, bit 13 set (>= 8192) -> saturate.
    always_comb begin
        pot = sum[SUM_WIDTH-1:0];
        if (sum[SUM_WIDTH+1]) begin
            pot = '0;
        end else if (sum[SUM_WIDTH]) begin
            pot = POT_MAX;
        end
    end

    assign spike   = (pot >= THR);
    assign res_out = spike ? (pot - THR) : pot;

endmodule

// File: rtl/snn_neuron_update.sv
// -----------------------------------------------------------------------------
// snn_neuron_update
// Per-SPE leaky integrate-and-fire update stage feeding output memory.
// One partial sum per neuron; in timestep 2 the stored residual is fetched
// from output memory first. Each neuron produces one STORE packet
// {dest=OMEM_ADDR, op=2*SPE_ID, data={11'd0, residual, spike}}.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   psum_valid/ready/data   13-bit signed partial sum input
//   tx_valid/ready/packet   33-bit router packet output
//   rx_valid/ready/packet   33-bit router packet input (always drained)
//   busy                    high in any state but IDLE/DONE
//   layer_done              high in DONE, held until reset
//   err                     sticky: unexpected or misaddressed rx packet
// Option SNN_LEAK_EN: leak the fetched residual by LEAK_SHIFT (snn_lif_core).
//
// Handshakes (psum, tx, rx): a transfer happens on a rising edge where
// valid && ready. A source holding valid keeps its payload stable and does
// not drop valid until the transfer; only reset abandons an offered tx packet.
// -----------------------------------------------------------------------------
module snn_neuron_update
    import snn_pkg::*;
#(
    parameter int SPE_ID         = 0,
    parameter int OMEM_ADDR      = 11,
    parameter int THRESHOLD      = 64,
    parameter int NEURONS_PER_TS = 89,
    parameter int LEAK_SHIFT     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [SUM_WIDTH-1:0] psum_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [PKT_WIDTH-1:0] tx_packet,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [PKT_WIDTH-1:0] rx_packet,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err
);

    localparam int NIDX_W = $clog2(NEURONS_PER_TS + 1);

    localparam logic [DEST_WIDTH-1:0] DEST_OMEM = DEST_WIDTH'(OMEM_ADDR);
    localparam logic [DEST_WIDTH-1:0] MY_ID     = DEST_WIDTH'(SPE_ID);
    localparam logic [OP_WIDTH-1:0]   STORE_OP  = OP_STORE_BASE + OP_WIDTH'(2 * SPE_ID);
    localparam logic [OP_WIDTH-1:0]   REQ_OP    = OP_REQ_BASE + OP_WIDTH'(2 * SPE_ID);
    localparam logic [NIDX_W-1:0]     LAST_NIDX = NIDX_W'(NEURONS_PER_TS - 1);

    state_t                      state;
    state_t                      state_nx;
    logic                        ts2;        // 0: timestep 1, 1: timestep 2
    logic [NIDX_W-1:0]           nidx;
    logic signed [SUM_WIDTH-1:0] psum_q;
    logic [SUM_WIDTH-1:0]        res_q;
    logic [SUM_WIDTH-1:0]        res_out_q;
    logic                        spike_q;
    logic                        err_q;

    logic [SUM_WIDTH-1:0]        lif_res;
    logic                        lif_spike;

    packet_t                     rx_pkt;
    logic                        rx_for_me;
    logic                        rx_is_tsd;
    logic                        res_hit;
    logic                        tsd_hit;
    logic                        rx_drop;
    logic                        unused_rx_data;

    assign rx_pkt         = packet_t'(rx_packet);
    assign unused_rx_data = ^rx_pkt.data[DATA_WIDTH-1:SUM_WIDTH];

    // rx_ready is high whenever out of reset, so rx_valid alone marks a
    // consumed packet for the state registers (they are held in reset anyway).
    assign rx_for_me = (rx_pkt.dest == MY_ID);
    assign rx_is_tsd = (rx_pkt.opcode == OP_TIMESTEP_DONE);
    assign res_hit   = rx_valid && rx_for_me && !rx_is_tsd && (state == ST_WAIT_RES);
    assign tsd_hit   = rx_valid && rx_for_me &&  rx_is_tsd && (state == ST_WAIT_TS);
    assign rx_drop   = rx_valid && !(res_hit || tsd_hit);

    snn_lif_core #(
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .psum    (psum_q),
        .res     (res_q),
        .res_out (lif_res),
        .spike   (lif_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ts2       <= 1'b0;
            nidx      <= '0;
            psum_q    <= '0;
            res_q     <= '0;
            res_out_q <= '0;
            spike_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && psum_valid) begin
                psum_q <= psum_data;
                if (!ts2) begin
                    res_q <= '0;
                end
            end
            if (res_hit) begin
                res_q <= rx_pkt.data[SUM_WIDTH-1:0];
            end
            if (state == ST_COMPUTE) begin
                res_out_q <= lif_res;
                spike_q   <= lif_spike;
            end
            if (state == ST_SEND && tx_ready) begin
                nidx <= nidx + NIDX_W'(1);
            end
            if (tsd_hit) begin
                ts2  <= 1'b1;
                nidx <= '0;
            end
            if (rx_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        psum_ready = 1'b0;
        tx_valid   = 1'b0;
        tx_packet  = '0;
        layer_done = 1'b0;
        case (state)
            ST_IDLE: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    state_nx = ts2 ? ST_REQ : ST_COMPUTE;
                end
            end
            ST_REQ: begin
                tx_valid  = 1'b1;
                tx_packet = make_packet(DEST_OMEM, REQ_OP, '0);
                if (tx_ready) begin
                    state_nx = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (res_hit) begin
                    state_nx = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                state_nx = ST_SEND;
            end
            ST_SEND: begin
                tx_valid  = 1'b1;
                tx_packet = make_packet(DEST_OMEM, STORE_OP, {11'd0, res_out_q, spike_q});
                if (tx_ready) begin
                    if (nidx == LAST_NIDX) begin
                        state_nx = ts2 ? ST_DONE : ST_WAIT_TS;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_WAIT_TS: begin
                if (tsd_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DONE: begin
                layer_done = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // The async reset parks state in IDLE, which would otherwise show
        // psum_ready=1 while rst_n is still low.
        if (!rst_n) begin
            psum_ready = 1'b0;
        end
    end

    assign rx_ready = rst_n;
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_snn_neuron_update.sv
module tb_snn_neuron_update;

    localparam int SPE_ID = 2;
    localparam int OMEM   = 11;
    localparam int THR    = 64;
    localparam int NPT    = 89;
    localparam int LEAK   = 1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        psum_valid;
    logic        psum_ready;
    logic [12:0] psum_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [32:0] tx_packet;
    logic        rx_valid;
    logic        rx_ready;
    logic [32:0] rx_packet;
    logic        busy;
    logic        layer_done;
    logic        err;

    snn_neuron_update #(
        .SPE_ID         (SPE_ID),
        .OMEM_ADDR      (OMEM),
        .THRESHOLD      (THR),
        .NEURONS_PER_TS (NPT),
        .LEAK_SHIFT     (LEAK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_data  (psum_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_packet  (tx_packet),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_packet  (rx_packet),
        .busy       (busy),
        .layer_done (layer_done),
        .err        (err)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic        exp_err = 1'b0;
    logic        exp_done = 1'b0;
    logic        model_ts2 = 1'b0;
    int          ts2_stores = 0;
    int          tx_count = 0;
    int          req_count = 0;
    logic [32:0] last_tx = '0;
    logic        bp_hold = 1'b0;
    logic        bp_rand = 1'b0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_pkt = '0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout actual=no_event required=event at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [32:0] store_pkt(input int psum, input int res_raw);
        int r;
        int pot;
        int spike;
        int res;
        r = res_raw;
`ifdef SNN_LEAK_EN
        r = r >> LEAK;
`endif
        pot = psum + r;
        if (pot < 0) pot = 0;
        if (pot > 8191) pot = 8191;
        spike = (pot >= THR) ? 1 : 0;
        res = (spike == 1) ? pot - THR : pot;
        return {4'(OMEM), 4'(2 * SPE_ID), 25'(res * 2 + spike)};
    endfunction

    function automatic logic [32:0] req_pkt();
        return {4'(OMEM), 4'(2 * SPE_ID + 1), 25'd0};
    endfunction

    function automatic int rand_psum();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 8191)) - 4096;
        return int'($urandom_range(0, 200)) - 50;
    endfunction

    // ---------------- tx backpressure driver ----------------
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold) tx_ready = 1'b0;
            else if (bp_rand) tx_ready = ($urandom_range(0, 3) != 0);
            else tx_ready = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
            ts2_stores = 0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 33'(tx_valid), 33'd1);
                check("tx_hold_packet", tx_packet, prev_pkt);
            end
            if (tx_valid) check("psum_ready_while_tx", 33'(psum_ready), 33'd0);
            check("err", 33'(err), 33'(exp_err));
            check("layer_done", 33'(layer_done), 33'(exp_done));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", tx_packet, 33'h0_0000_0000 ^ {33{1'b1}});
                end else begin
                    e = exp_q.pop_front();
                    check("tx_packet", tx_packet, e);
                end
                last_tx = tx_packet;
                tx_count++;
                if (tx_packet[28:25] == 4'(2 * SPE_ID + 1)) begin
                    req_count++;
                end else if (model_ts2) begin
                    ts2_stores++;
                    if (ts2_stores == NPT) exp_done = 1'b1;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_pkt   = tx_packet;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_psum(input int v);
        int n;
        n = 0;
        psum_valid = 1'b1;
        psum_data  = 13'(v);
        @(negedge clk);
        while (!psum_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!psum_ready) fail_timeout("psum_accept");
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [32:0] pkt);
        int n;
        n = 0;
        rx_valid  = 1'b1;
        rx_packet = pkt;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) fail_timeout("rx_accept");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target, input string name);
        int n;
        n = 0;
        while (tx_count < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_count < target) fail_timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int target);
        int n;
        n = 0;
        while (req_count < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (req_count < target) fail_timeout("req_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic ts1_neuron(input int p);
        exp_q.push_back(store_pkt(p, 0));
        push_psum(p);
    endtask

    task automatic ts2_neuron(input int p, input int r);
        int rb;
        rb = req_count;
        exp_q.push_back(req_pkt());
        exp_q.push_back(store_pkt(p, r));
        push_psum(p);
        wait_req(rb + 1);
        send_rx({4'(SPE_ID), 4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095)), 13'(r)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psum_ready"}, 33'(psum_ready), 33'd0);
        check({tag, "_tx_valid"}, 33'(tx_valid), 33'd0);
        check({tag, "_rx_ready"}, 33'(rx_ready), 33'd0);
        check({tag, "_busy"}, 33'(busy), 33'd0);
        check({tag, "_layer_done"}, 33'(layer_done), 33'd0);
        check({tag, "_err"}, 33'(err), 33'd0);
        check({tag, "_tx_packet"}, tx_packet, 33'd0);
    endtask

    task automatic do_ts1_random(input int count);
        int base;
        base = tx_count;
        bp_rand = 1'b1;
        for (int i = 0; i < count; i++) begin
            ts1_neuron(rand_psum());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_tx(base + count, "ts1_drain");
        bp_rand = 1'b0;
    endtask

    task automatic do_ts2_random(input int count);
        int base;
        base = tx_count;
        bp_rand = 1'b1;
        for (int i = 0; i < count; i++) begin
            ts2_neuron(rand_psum(), int'($urandom_range(0, 8191)));
        end
        wait_tx(base + 2 * count, "ts2_drain");
        bp_rand = 1'b0;
    endtask

    task automatic enter_ts2();
        check("wait_ts_psum_ready", 33'(psum_ready), 33'd0);
        check("wait_ts_busy", 33'(busy), 33'd1);
        send_rx({4'(SPE_ID), 4'd15, 25'd0});
        model_ts2 = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        psum_valid = 1'b0;
        psum_data  = '0;
        rx_valid   = 1'b0;
        rx_packet  = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_psum_ready", 33'(psum_ready), 33'd1);
        check("post_reset_busy", 33'(busy), 33'd0);

        // psum 100 in ts1 -> res 36, spike 1
        base = tx_count;
        ts1_neuron(100);
        wait_tx(base + 1, "t1");
        check("t1_store", last_tx, {4'd11, 4'd4, 25'd73});

        // negative sum clamps to 0
        base = tx_count;
        ts1_neuron(-20);
        wait_tx(base + 1, "t2");
        check("t2_clamp0", last_tx, {4'd11, 4'd4, 25'd0});

        // backpressure: tx_ready low 5 cycles in SEND
        base = tx_count;
        bp_hold = 1'b1;
        ts1_neuron(50);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_tx_valid", 33'(tx_valid), 33'd1);
            check("bp_tx_packet", tx_packet, {4'd11, 4'd4, 25'd100});
            check("bp_psum_ready", 33'(psum_ready), 33'd0);
        end
        bp_hold = 1'b0;
        wait_tx(base + 1, "t4");
        check("t4_store", last_tx, {4'd11, 4'd4, 25'd100});

        // rest of timestep 1, then TIMESTEP_DONE
        do_ts1_random(NPT - 3);
        enter_ts2();

        // ts2: psum 30, a stray opcode 15 while waiting, then reply 40
        base = tx_count;
        exp_q.push_back(req_pkt());
`ifdef SNN_LEAK_EN
        exp_q.push_back(store_pkt(30, 40));
`else
        exp_q.push_back(store_pkt(30, 40));
`endif
        push_psum(30);
        wait_req(req_count + 1);
        check("t3_req", last_tx, {4'd11, 4'd5, 25'd0});
        send_rx({4'(SPE_ID), 4'd15, 25'd0});
        exp_err = 1'b1;
        check("t3_err_tsd_in_wait_res", 33'(err), 33'd1);
        check("t3_still_busy", 33'(busy), 33'd1);
        send_rx({4'(SPE_ID), 4'd4, 25'd40});
        wait_tx(base + 2, "t3");
`ifdef SNN_LEAK_EN
        check("t3_store", last_tx, {4'd11, 4'd4, 25'd100});
`else
        check("t3_store", last_tx, {4'd11, 4'd4, 25'd13});
`endif

        do_ts2_random(5);

        // reset while waiting for a residual
        bp_rand = 1'b1;
        exp_q.push_back(req_pkt());
        push_psum(rand_psum());
        wait_req(req_count + 1);
        check("t6_pre_busy", 33'(busy), 33'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_err   = 1'b0;
        model_ts2 = 1'b0;
        bp_rand   = 1'b0;
        check_reset_outputs("t6_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_psum_ready", 33'(psum_ready), 33'd1);
        check("t6_busy", 33'(busy), 33'd0);

        // misaddressed packet and early TIMESTEP_DONE are dropped with err
        send_rx({4'd3, 4'd4, 25'd7});
        exp_err = 1'b1;
        check("t5_err_dest", 33'(err), 33'd1);
        send_rx({4'(SPE_ID), 4'd15, 25'd0});
        check("t5_idle_unaffected", 33'(psum_ready), 33'd1);
        base = tx_count;
        ts1_neuron(100);
        wait_tx(base + 1, "t5");
        check("t5_store_ts1", last_tx, {4'd11, 4'd4, 25'd73});

        // full layer
        do_ts1_random(NPT - 1);
        enter_ts2();
        do_ts2_random(NPT);
        @(negedge clk);
        check("done_layer_done", 33'(layer_done), 33'd1);
        check("done_busy", 33'(busy), 33'd0);
        psum_valid = 1'b1;
        psum_data  = 13'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_psum_ready", 33'(psum_ready), 33'd0);
        end
        psum_valid = 1'b0;
        @(negedge clk);
        check("final_exp_q_empty", 33'(exp_q.size()), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
